pueo_trig_meta_capture: RTL
===========================

# pueo_trig_meta_capture

Consumer of the level-two trigger decision. On every master trigger pulse it snapshots the four aligned 64-bit TURFIO metadata words, tags them with an event number and timestamp, and queues them in an event FIFO. Queued events drain as 5-beat packets on a 64-bit valid/ready stream toward the event builder. Sits directly downstream of the L2 trigger, in the same sysclk domain.

## Interface

Parameters:
- FIFO_DEPTH, 16: event entries; power of two, 4 to 64.
- TS_WIDTH, 32: timestamp counter width; fixed at 32, other values unsupported.

Ports:
- clk_i  in  1  sysclk; all logic on rising edge.
- rst_n_i  in  1  asynchronous, active-low reset; deassertion synchronous to clk_i upstream.
- ce_i  in  1  sysclk_x2 phase enable; timestamp advances only when high.
- trig_i  in  1  master trigger; single-cycle pulse, one event per high cycle.
- tio0_meta_i .. tio3_meta_i  in  64 each  metadata, already aligned to trig_i; sampled on the trig_i cycle.
- runrst_i  in  1  synchronous run reset pulse.
- m_tdata  out  64  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  high on beat 4 of each packet.
- occupancy_o  out  7  entries held: stored plus the one being streamed.
- drop_count_o  out  16  saturating count of triggers dropped because the FIFO was full.

## Operation

- Event counter (32 b): value captured, then incremented, on every trig_i, including dropped triggers. Dropped events therefore leave gaps in the sequence. Wraps 0xFFFFFFFF -> 0.
- Timestamp (32 b): increments on each cycle with ce_i high. Wraps. The captured value is the pre-increment value at the trig_i edge.
- Entry layout (320 b): {event_no, timestamp, meta0, meta1, meta2, meta3}.
- Write: trig_i high and occupancy < FIFO_DEPTH -> entry written. Otherwise the trigger is dropped and drop_count_o increments, saturating at 0xFFFF.
- Full check uses occupancy before the edge. A write arriving on the same edge that frees the last beat of a full FIFO is still dropped.
- Read FSM states:
  - IDLE: m_tvalid=0. Go to LOAD when FIFO is non-empty.
  - LOAD: head entry copied to the output register and beat counter set to 0. Go to STREAM.
  - STREAM: beats presented in order:
    - beat 0 = {event_no[31:0], timestamp[31:0]}, event_no in [63:32]
    - beats 1-4 = meta0..meta3
    - m_tlast on beat 4.
  - STREAM advance: beat counter advances only on m_tvalid && m_tready.
  - STREAM exit: on accept of beat 4, occupancy decrements. Next state is LOAD if further entries remain, else IDLE.
- m_tdata, m_tlast and m_tvalid are stable while m_tvalid && !m_tready. m_tvalid never drops without a handshake.
- runrst_i clears the event counter, timestamp and drop_count_o on the next edge. It does not flush the FIFO or interrupt streaming. A trig_i in the same cycle is captured with event_no=0 and timestamp=0, then the counters restart from 1 and 0 respectively.
- Simultaneous write and final-beat read at occupancy < FIFO_DEPTH: occupancy is unchanged.

## Timing

- Reset values (asynchronous on rst_n_i low): m_tvalid=0, m_tlast=0, m_tdata=0, occupancy_o=0, drop_count_o=0, event counter=0, timestamp=0, FSM=IDLE.
- Reset asserted mid-packet: the packet and all queued entries are discarded with no further beats.
- Latency: trig_i sampled at edge k with the FIFO empty and the FSM idle -> occupancy_o=1 after edge k, LOAD after edge k+1, m_tvalid=1 with beat 0 after edge k+2.
- Back-to-back packets: one LOAD bubble cycle between beat 4 accept and beat 0 of the next packet. Maximum throughput is 5 of 6 cycles.
- trig_i is accepted on every cycle, including consecutive cycles. Behaviour is not gated by ce_i.
- drop_count_o and occupancy_o are registered and update on the edge of the causing event.

## Test plan

- Single event: reset, drive timestamp to 0x10 with ce_i continuous, pulse trig_i with meta0..3 = 0xA0..0xA3 patterns, m_tready=1 -> 5 beats starting 2 edges later. Beat 0 = 0x00000000_00000010, beats 1-4 = metas, m_tlast only on beat 4, occupancy 1 -> 0.
- Backpressure: hold m_tready=0 for 10 cycles mid-packet at beat 2 -> m_tdata/m_tlast/m_tvalid stable, no beat skipped or repeated.
- Overflow: FIFO_DEPTH=16, m_tready=0, 20 consecutive trig_i -> occupancy_o=16, drop_count_o=4. After draining, the first 16 packets carry event_no 0..15 and the next trigger carries event_no 20.
- Full + simultaneous free: FIFO full, trig_i on the same edge as the beat 4 accept -> trigger dropped, drop_count_o +1, occupancy_o 15.
- runrst_i with queued entries: 3 events queued, pulse runrst_i, then trigger -> the 3 queued packets are unchanged, and the new packet has event_no=0 with timestamp equal to the number of ce_i cycles since runrst_i.
- Async reset mid-packet: drop rst_n_i during beat 3 -> m_tvalid low immediately. After release, all outputs are at reset values and the next trigger yields event_no=0.

Source files
------------

// File: rtl/pueo_trig_meta_capture.sv
// Trigger metadata capture: snapshots the four TURFIO metadata words on each master
// trigger, tags them with event number and timestamp, and streams them as 5-beat packets.
module pueo_trig_meta_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        ce_i,
    input  logic        trig_i,
    input  logic [63:0] tio0_meta_i,
    input  logic [63:0] tio1_meta_i,
    input  logic [63:0] tio2_meta_i,
    input  logic [63:0] tio3_meta_i,
    input  logic        runrst_i,
    output logic [63:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [6:0]  occupancy_o,
    output logic [15:0] drop_count_o
);
    // state  | meaning
    // IDLE   | nothing in flight, waiting for a queued event
    // LOAD   | head entry copied into the holding register
    // STREAM | beats 0..4 of the held entry presented on the stream
    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;

    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [6:0] DEPTH_C = 7'(FIFO_DEPTH);

    state_t              state;
    logic [31:0]         event_no;
    logic [TS_WIDTH-1:0] timestamp;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [319:0]        mem [FIFO_DEPTH];
    logic [319:0]        hold;
    logic [2:0]          beat;

    logic                wr_en;
    logic                drop;
    logic                rd_done;
    logic [6:0]          occ_next;
    logic [31:0]         cap_evt;
    logic [TS_WIDTH-1:0] cap_ts;
    logic [319:0]        entry_in;

    function automatic logic [63:0] beat_word(input logic [319:0] e, input logic [2:0] b);
        case (b)
            3'd0:    beat_word = e[319:256];
            3'd1:    beat_word = e[255:192];
            3'd2:    beat_word = e[191:128];
            3'd3:    beat_word = e[127:64];
            default: beat_word = e[63:0];
        endcase
    endfunction

    // Full check uses pre-edge occupancy, so a same-edge free does not make room.
    assign wr_en    = trig_i && (occupancy_o < DEPTH_C);
    assign drop     = trig_i && !wr_en;
    assign rd_done  = m_tvalid && m_tready && m_tlast;
    assign occ_next = occupancy_o + {6'd0, wr_en} - {6'd0, rd_done};

    // A run reset coinciding with a trigger tags that event as the first of the new run.
    assign cap_evt  = runrst_i ? '0 : event_no;
    assign cap_ts   = runrst_i ? '0 : timestamp;
    assign entry_in = {cap_evt, cap_ts, tio0_meta_i, tio1_meta_i, tio2_meta_i, tio3_meta_i};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            event_no     <= '0;
            timestamp    <= '0;
            drop_count_o <= '0;
        end else if (runrst_i) begin
            event_no     <= {31'd0, trig_i};
            timestamp    <= '0;
            drop_count_o <= {15'd0, drop};
        end else begin
            if (trig_i)
                event_no <= event_no + 32'd1;
            if (ce_i)
                timestamp <= timestamp + TS_WIDTH'(1);
            if (drop && drop_count_o != 16'hFFFF)
                drop_count_o <= drop_count_o + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            occupancy_o <= '0;
            wr_ptr      <= '0;
        end else begin
            occupancy_o <= occ_next;
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[wr_ptr] <= entry_in;
    end

    // The streamed entry keeps its slot until beat 4 is accepted; rd_ptr moves only then.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            hold     <= '0;
            beat     <= '0;
            rd_ptr   <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    m_tvalid <= 1'b0;
                    m_tlast  <= 1'b0;
                    if (occupancy_o != 7'd0)
                        state <= LOAD;
                end
                LOAD: begin
                    hold     <= mem[rd_ptr];
                    m_tdata  <= beat_word(mem[rd_ptr], 3'd0);
                    m_tvalid <= 1'b1;
                    m_tlast  <= 1'b0;
                    beat     <= 3'd0;
                    state    <= STREAM;
                end
                STREAM: begin
                    if (m_tready) begin
                        if (beat == 3'd4) begin
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            rd_ptr   <= rd_ptr + AW'(1);
                            state    <= (occ_next != 7'd0) ? LOAD : IDLE;
                        end else begin
                            beat    <= beat + 3'd1;
                            m_tdata <= beat_word(hold, beat + 3'd1);
                            m_tlast <= (beat == 3'd3);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
